mat_stream_reader: RTL and testbench

Reads one ROWS×COLS matrix from a synchronous-read memory (1-cycle read latency) and emits it as a valid/ready element stream. The stream is row-major, or column-major when transposed. It sits upstream of the element FIFOs that feed the multiply array; its stream port connects directly to a FIFO write side. It absorbs memory latency and downstream backpressure through a 2-entry output buffer with credit-based read issue.

---
 rtl/mat_stream_reader.sv | 175 +++++++++++++++++
 tb/tb_mat_stream_reader.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_stream_reader.sv
// rtl/mat_stream_reader.sv - streams one ROWS x COLS matrix from a 1-cycle-latency memory
// Reads are credit-gated so the 2-entry output buffer never overflows under backpressure.
module mat_stream_reader #(
   parameter int W    = 16,
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int AW   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          transpose,
   output logic          busy,
   output logic          done,
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   input  logic [W-1:0]  mem_rdata,
   output logic [W-1:0]  m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_row_last,
   output logic          m_last
);
   localparam int N  = ROWS * COLS;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          tr_q, tr_d;
   logic [RW-1:0] r_q, r_d;
   logic [CW-1:0] c_q, c_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          infl_q, infl_d;
   logic          infl_rl_q, infl_rl_d;
   logic          infl_last_q, infl_last_d;
   logic [1:0]    occ_q, occ_d;
   logic [W-1:0]  d0_q, d0_d, d1_q, d1_d;
   logic          rl0_q, rl0_d, rl1_q, rl1_d;
   logic          l0_q, l0_d, l1_q, l1_d;

   logic          pop, push, issue, row_end, final_rd;
   logic [2:0]    credit_use;
   logic [AW-1:0] addr;

   assign m_valid    = (occ_q != 2'd0);
   assign m_data     = d0_q;
   assign m_row_last = rl0_q;
   assign m_last     = l0_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign mem_en     = issue;
   assign mem_addr   = issue ? addr : '0;

   always_comb begin
      pop        = m_valid & m_ready;
      push       = infl_q;
      credit_use = 3'(occ_q) + 3'(infl_q) - 3'(pop);
      row_end    = tr_q ? (r_q == RW'(ROWS - 1)) : (c_q == CW'(COLS - 1));
      final_rd   = (cnt_q == AW'(N - 1));
      issue      = (state_q == S_RUN) && (credit_use < 3'd2);
      addr       = AW'(r_q) * AW'(COLS) + AW'(c_q);

      infl_d      = issue;
      infl_rl_d   = row_end;
      infl_last_d = final_rd;

      // Head is slot 0; a push lands in the head only when the head is free after this cycle's pop.
      occ_d = occ_q + 2'(push) - 2'(pop);
      d0_d  = d0_q;
      d1_d  = d1_q;
      rl0_d = rl0_q;
      rl1_d = rl1_q;
      l0_d  = l0_q;
      l1_d  = l1_q;
      if (pop) begin
         d0_d  = d1_q;
         rl0_d = rl1_q;
         l0_d  = l1_q;
      end
      if (push) begin
         if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) begin
            d0_d  = mem_rdata;
            rl0_d = infl_rl_q;
            l0_d  = infl_last_q;
         end else begin
            d1_d  = mem_rdata;
            rl1_d = infl_rl_q;
            l1_d  = infl_last_q;
         end
      end

      state_d = state_q;
      tr_d    = tr_q;
      r_d     = r_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               tr_d    = transpose;
               r_d     = '0;
               c_d     = '0;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (issue) begin
               if (final_rd) begin
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + AW'(1);
                  if (!tr_q) begin
                     if (row_end) begin
                        c_d = '0;
                        r_d = r_q + RW'(1);
                     end else begin
                        c_d = c_q + CW'(1);
                     end
                  end else begin
                     if (row_end) begin
                        r_d = '0;
                        c_d = c_q + CW'(1);
                     end else begin
                        r_d = r_q + RW'(1);
                     end
                  end
               end
            end
         end
         // Looking at next occupancy lets done follow the final handshake by one cycle.
         S_DRAIN: if (occ_d == 2'd0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tr_q        <= 1'b0;
         r_q         <= '0;
         c_q         <= '0;
         cnt_q       <= '0;
         infl_q      <= 1'b0;
         infl_rl_q   <= 1'b0;
         infl_last_q <= 1'b0;
         occ_q       <= 2'd0;
         d0_q        <= '0;
         d1_q        <= '0;
         rl0_q       <= 1'b0;
         rl1_q       <= 1'b0;
         l0_q        <= 1'b0;
         l1_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         tr_q        <= tr_d;
         r_q         <= r_d;
         c_q         <= c_d;
         cnt_q       <= cnt_d;
         infl_q      <= infl_d;
         infl_rl_q   <= infl_rl_d;
         infl_last_q <= infl_last_d;
         occ_q       <= occ_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         rl0_q       <= rl0_d;
         rl1_q       <= rl1_d;
         l0_q        <= l0_d;
         l1_q        <= l1_d;
      end
   end
endmodule

// File: tb/tb_mat_stream_reader.sv
// tb/tb_mat_stream_reader.sv - directed and random-ready bench for mat_stream_reader
// Instance a is 2x3 with mem[a]=a+0x10; instance b is 8x8 with mem[a]=5*a+0x200.
module tb_mat_stream_reader;
   localparam int W   = 16;
   localparam int AWA = 3;
   localparam int AWB = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic           start_a = 1'b0;
   logic           tr_a = 1'b0;
   logic           m_ready_a = 1'b0;
   logic           busy_a, done_a, mem_en_a, m_valid_a, m_row_last_a, m_last_a;
   logic [AWA-1:0] mem_addr_a;
   logic [W-1:0]   mem_rdata_a = '0;
   logic [W-1:0]   m_data_a;

   logic           start_b = 1'b0;
   logic           tr_b = 1'b0;
   logic           m_ready_b = 1'b0;
   logic           busy_b, done_b, mem_en_b, m_valid_b, m_row_last_b, m_last_b;
   logic [AWB-1:0] mem_addr_b;
   logic [W-1:0]   mem_rdata_b = '0;
   logic [W-1:0]   m_data_b;

   mat_stream_reader #(.W(W), .ROWS(2), .COLS(3)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .transpose(tr_a), .busy(busy_a), .done(done_a),
      .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a), .m_data(m_data_a),
      .m_valid(m_valid_a), .m_ready(m_ready_a), .m_row_last(m_row_last_a), .m_last(m_last_a)
   );

   mat_stream_reader #(.W(W), .ROWS(8), .COLS(8)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .transpose(tr_b), .busy(busy_b), .done(done_b),
      .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .m_data(m_data_b),
      .m_valid(m_valid_b), .m_ready(m_ready_b), .m_row_last(m_row_last_b), .m_last(m_last_b)
   );

   always @(posedge clk) begin
      if (mem_en_a) mem_rdata_a <= 16'(mem_addr_a) + 16'h0010;
      if (mem_en_b) mem_rdata_b <= 16'(mem_addr_b) * 16'd5 + 16'h0200;
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if ({busy_a, done_a, mem_en_a, m_valid_a, m_row_last_a, m_last_a} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags_a got %b exp 000000", {busy_a, done_a, mem_en_a, m_valid_a, m_row_last_a, m_last_a});
      end
      checks++;
      if (mem_addr_a !== 3'd0 || m_data_a !== 16'h0000) begin
         errors++;
         $display("FAIL reset_addr_data_a got addr=%0d data=%h exp 0 0000", mem_addr_a, m_data_a);
      end
      checks++;
      if ({busy_b, done_b, mem_en_b, m_valid_b, m_row_last_b, m_last_b} !== 6'b0 || mem_addr_b !== 6'd0 || m_data_b !== 16'h0000) begin
         errors++;
         $display("FAIL reset_b got flags=%b addr=%0d data=%h exp all zero",
                  {busy_b, done_b, mem_en_b, m_valid_b, m_row_last_b, m_last_b}, mem_addr_b, m_data_b);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #3;
      checks++;
      if (busy_a !== 1'b0 || mem_en_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got busy=%b en=%b exp 0 0", busy_a, mem_en_a);
      end
   endtask

   task automatic test_stream(input logic tr);
      int ea [6];
      int ed [6];
      logic [5:0] erl;
      logic exp_v, exp_rl, exp_l;
      logic [W-1:0] exp_d;
      if (!tr) begin
         ea  = '{0, 1, 2, 3, 4, 5};
         ed  = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15};
         erl = 6'b100100;
      end else begin
         ea  = '{0, 3, 1, 4, 2, 5};
         ed  = '{'h10, 'h13, 'h11, 'h14, 'h12, 'h15};
         erl = 6'b101010;
      end
      @(posedge clk); #1;
      start_a = 1'b1; tr_a = tr; m_ready_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         #3;
         checks++;
         if (c <= 6) begin
            if (mem_en_a !== 1'b1 || mem_addr_a !== AWA'(ea[c-1])) begin
               errors++;
               $display("FAIL stream_read tr=%0d c=%0d got en=%b addr=%0d exp en=1 addr=%0d", tr, c, mem_en_a, mem_addr_a, ea[c-1]);
            end
         end else if (mem_en_a !== 1'b0) begin
            errors++;
            $display("FAIL stream_no_read tr=%0d c=%0d got en=%b exp 0", tr, c, mem_en_a);
         end
         exp_v = (c >= 3 && c <= 8);
         checks++;
         if (m_valid_a !== exp_v) begin
            errors++;
            $display("FAIL stream_valid tr=%0d c=%0d got %b exp %b", tr, c, m_valid_a, exp_v);
         end
         if (exp_v) begin
            exp_d  = 16'(ed[c-3]);
            exp_rl = erl[c-3];
            exp_l  = (c == 8);
            checks++;
            if (m_data_a !== exp_d || m_row_last_a !== exp_rl || m_last_a !== exp_l) begin
               errors++;
               $display("FAIL stream_beat tr=%0d c=%0d got d=%h rl=%b l=%b exp d=%h rl=%b l=%b",
                        tr, c, m_data_a, m_row_last_a, m_last_a, exp_d, exp_rl, exp_l);
            end
         end
         checks++;
         if (done_a !== (c == 9) || busy_a !== (c != 10)) begin
            errors++;
            $display("FAIL stream_done_busy tr=%0d c=%0d got done=%b busy=%b exp done=%b busy=%b",
                     tr, c, done_a, busy_a, (c == 9), (c != 10));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int popped = 0;
      int issued = 0;
      int stall = 0;
      int max_out = 0;
      int cyc = 0;
      bit finished = 1'b0;
      logic [W-1:0] beats [$];
      @(posedge clk); #1;
      start_a = 1'b1; tr_a = 1'b0; m_ready_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      while (!finished && cyc < 60) begin
         m_ready_a = !(popped == 2 && stall < 5);
         if (!m_ready_a) stall++;
         #3;
         if (!m_ready_a) begin
            checks++;
            if (mem_en_a !== 1'b0 || m_valid_a !== 1'b1 || m_data_a !== 16'h0012) begin
               errors++;
               $display("FAIL bp_stall cyc=%0d got en=%b v=%b d=%h exp en=0 v=1 d=0012", cyc, mem_en_a, m_valid_a, m_data_a);
            end
         end
         if (mem_en_a === 1'b1) issued++;
         if (m_valid_a === 1'b1 && m_ready_a) begin
            beats.push_back(m_data_a);
            popped++;
         end
         if (issued - popped > max_out) max_out = issued - popped;
         if (done_a === 1'b1) finished = 1'b1;
         cyc++;
         @(posedge clk); #1;
      end
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL bp_timeout got no done exp done within 60 cycles");
      end
      checks++;
      if (beats.size() != 6) begin
         errors++;
         $display("FAIL bp_count got %0d exp 6", beats.size());
      end
      foreach (beats[k]) begin
         checks++;
         if (beats[k] !== 16'(k + 'h10)) begin
            errors++;
            $display("FAIL bp_order beat=%0d got %h exp %h", k, beats[k], 16'(k + 'h10));
         end
      end
      checks++;
      if (max_out > 2 || stall != 5) begin
         errors++;
         $display("FAIL bp_outstanding got max=%0d stalls=%0d exp max<=2 stalls=5", max_out, stall);
      end
      #3;
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL bp_after_done got done=%b busy=%b exp 0 0", done_a, busy_a);
      end
   endtask

   task automatic test_start_ignored();
      int nb = 0;
      int last_cnt = 0;
      @(posedge clk); #1;
      start_a = 1'b1; tr_a = 1'b0; m_ready_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int c = 1; c <= 21; c++) begin
         start_a = (c == 2 || c == 7 || c == 9 || c == 10);
         tr_a    = (c == 2 || c == 7 || c == 9);
         #3;
         if (m_valid_a === 1'b1) begin
            checks++;
            if (m_data_a !== 16'((nb % 6) + 'h10)) begin
               errors++;
               $display("FAIL si_beat n=%0d got %h exp %h", nb, m_data_a, 16'((nb % 6) + 'h10));
            end
            if (m_last_a === 1'b1) last_cnt++;
            nb++;
         end
         checks++;
         if (done_a !== (c == 9 || c == 19)) begin
            errors++;
            $display("FAIL si_done c=%0d got %b exp %b", c, done_a, (c == 9 || c == 19));
         end
         if (c == 3 || c == 12) begin
            checks++;
            if (mem_en_a !== 1'b1 || mem_addr_a !== ((c == 3) ? 3'd2 : 3'd1)) begin
               errors++;
               $display("FAIL si_walk c=%0d got en=%b addr=%0d exp en=1 addr=%0d", c, mem_en_a, mem_addr_a, (c == 3) ? 2 : 1);
            end
         end
         if (c == 7 || c == 8) begin
            checks++;
            if (busy_a !== 1'b1 || mem_en_a !== 1'b0) begin
               errors++;
               $display("FAIL si_drain c=%0d got busy=%b en=%b exp 1 0", c, busy_a, mem_en_a);
            end
         end
         if (c == 11) begin
            checks++;
            if (busy_a !== 1'b1 || mem_en_a !== 1'b1 || mem_addr_a !== 3'd0) begin
               errors++;
               $display("FAIL si_restart got busy=%b en=%b addr=%0d exp 1 1 0", busy_a, mem_en_a, mem_addr_a);
            end
         end
         @(posedge clk); #1;
      end
      start_a = 1'b0;
      checks++;
      if (nb != 12 || last_cnt != 2) begin
         errors++;
         $display("FAIL si_totals got beats=%0d lasts=%0d exp 12 2", nb, last_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      @(posedge clk); #1;
      start_a = 1'b1; tr_a = 1'b0; m_ready_a = 1'b0;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (3) @(posedge clk);
      #4;
      checks++;
      if (m_valid_a !== 1'b1 || m_data_a !== 16'h0010 || mem_en_a !== 1'b0) begin
         errors++;
         $display("FAIL rm_buffered got v=%b d=%h en=%b exp 1 0010 0", m_valid_a, m_data_a, mem_en_a);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy_a, done_a, mem_en_a, m_valid_a, m_row_last_a, m_last_a} !== 6'b0 || mem_addr_a !== 3'd0 || m_data_a !== 16'h0000) begin
         errors++;
         $display("FAIL rm_reset got flags=%b addr=%0d data=%h exp all zero",
                  {busy_a, done_a, mem_en_a, m_valid_a, m_row_last_a, m_last_a}, mem_addr_a, m_data_a);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #3;
         checks++;
         if (done_a !== 1'b0 || busy_a !== 1'b0 || m_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL rm_quiet c=%0d got done=%b busy=%b v=%b exp 0 0 0", c, done_a, busy_a, m_valid_a);
         end
         @(posedge clk); #1;
      end
      start_a = 1'b1; m_ready_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         #3;
         if (c == 1) begin
            checks++;
            if (mem_en_a !== 1'b1 || mem_addr_a !== 3'd0) begin
               errors++;
               $display("FAIL rm_restart_addr got en=%b addr=%0d exp 1 0", mem_en_a, mem_addr_a);
            end
         end
         if (c == 3) begin
            checks++;
            if (m_valid_a !== 1'b1 || m_data_a !== 16'h0010) begin
               errors++;
               $display("FAIL rm_restart_beat got v=%b d=%h exp 1 0010", m_valid_a, m_data_a);
            end
         end
         if (done_a === 1'b1) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rm_done got no done exp done after restart");
      end
   endtask

   task automatic test_random(input logic tr);
      int nb = 0;
      int last_cnt = 0;
      int done_cnt = 0;
      int cyc = 0;
      int r, c, ea;
      logic [W-1:0] exp_d;
      @(posedge clk); #1;
      start_b = 1'b1; tr_b = tr; m_ready_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      while (done_cnt == 0 && cyc < 1000) begin
         m_ready_b = 1'($urandom_range(0, 1));
         #3;
         if (m_valid_b === 1'b1 && m_ready_b) begin
            if (tr) begin
               r = nb % 8; c = nb / 8;
            end else begin
               r = nb / 8; c = nb % 8;
            end
            ea    = r * 8 + c;
            exp_d = 16'(ea * 5 + 'h200);
            checks++;
            if (m_data_b !== exp_d || m_row_last_b !== (nb % 8 == 7) || m_last_b !== (nb == 63)) begin
               errors++;
               $display("FAIL rand_beat tr=%0d n=%0d got d=%h rl=%b l=%b exp d=%h rl=%b l=%b",
                        tr, nb, m_data_b, m_row_last_b, m_last_b, exp_d, (nb % 8 == 7), (nb == 63));
            end
            if (m_last_b === 1'b1) last_cnt++;
            nb++;
         end
         if (done_b === 1'b1) done_cnt++;
         cyc++;
         @(posedge clk); #1;
      end
      #3;
      if (done_b === 1'b1) done_cnt++;
      checks++;
      if (nb != 64 || last_cnt != 1 || done_cnt != 1) begin
         errors++;
         $display("FAIL rand_totals tr=%0d got beats=%0d lasts=%0d dones=%0d exp 64 1 1", tr, nb, last_cnt, done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_stream(1'b0);
      test_stream(1'b1);
      test_backpressure();
      test_start_ignored();
      test_reset_mid();
      test_random(1'b0);
      test_random(1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
